snapshot_readout_bank: RTL and testbench

//   Parametrised N-channel sample snapshot bank for the ADC/metrology readout path.
//   - On a (decimated) sample strobe, latches all channel words atomically into a held bank.

---
 rtl/snapshot_readout_bank.sv | 123 ++++++++++++
 tb/tb_snapshot_readout_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/snapshot_readout_bank.sv
// N-channel sample snapshot bank: decimated atomic capture, hold/ack handshake,
// overrun accounting and a one-cycle-latency indexed read port.
module snapshot_readout_bank #(
    parameter  int unsigned N_CH   = 18,
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned CNT_W  = 32,
    parameter  int unsigned DEC_W  = 16,
    localparam int unsigned IDX_W  = $clog2(N_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   ch_data_i,
    input  logic                     sample_valid_i,
    input  logic                     enable_i,
    input  logic [DEC_W-1:0]         decim_i,
    input  logic                     frame_ack_i,
    output logic                     frame_ready_o,
    input  logic                     rd_req_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic                     rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [CNT_W-1:0]         frame_cnt_o,
    output logic [15:0]              overrun_cnt_o
);

    localparam int unsigned WIDE_W = (CNT_W > DATA_W) ? CNT_W : DATA_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DEC_W-1:0]  dcnt;
    logic [DATA_W-1:0] bank [N_CH];
    logic              cap_c;
    logic              load_c;
    logic              ovr_c;
    logic [WIDE_W-1:0] cnt_wide_c;
    logic [DATA_W-1:0] rd_word_c;

    // ">=" lets a runtime decrease of decim_i take effect on the very next strobe
    assign cap_c = sample_valid_i && enable_i && (dcnt >= decim_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt <= '0;
        end else if (!enable_i) begin
            dcnt <= '0;
        end else if (sample_valid_i) begin
            dcnt <= cap_c ? '0 : dcnt + DEC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cap_c) state_next = HOLD;
            HOLD:    if (frame_ack_i && !cap_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A capture in HOLD only replaces the frame when the consumer acks in the same cycle
    always_comb begin
        load_c = 1'b0;
        ovr_c  = 1'b0;
        case (state)
            IDLE: load_c = cap_c;
            HOLD: begin
                load_c = cap_c && frame_ack_i;
                ovr_c  = cap_c && !frame_ack_i;
            end
            default: ;
        endcase
    end

    assign frame_ready_o = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N_CH); k++) bank[k] <= '0;
            frame_cnt_o   <= '0;
            overrun_cnt_o <= '0;
        end else begin
            if (load_c) begin
                for (int k = 0; k < int'(N_CH); k++) bank[k] <= ch_data_i[k*DATA_W +: DATA_W];
                frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end
            if (ovr_c && (overrun_cnt_o != 16'hFFFF)) begin
                overrun_cnt_o <= overrun_cnt_o + 16'd1;
            end
        end
    end

    always_comb begin
        cnt_wide_c = WIDE_W'(frame_cnt_o);
        rd_word_c  = '0;
        if (rd_idx_i < IDX_W'(N_CH)) begin
            rd_word_c = bank[rd_idx_i];
        end else if (rd_idx_i == IDX_W'(N_CH)) begin
            rd_word_c = cnt_wide_c[DATA_W-1:0];
        end
    end

    // Read data samples the bank before any same-cycle capture lands
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) rd_data_o <= rd_word_c;
        end
    end

endmodule

// File: tb/tb_snapshot_readout_bank.sv
// Directed bench for snapshot_readout_bank: capture, decimation, overrun,
// simultaneous ack/capture, read-during-capture and reset.
module tb_snapshot_readout_bank;

    localparam int unsigned N_CH   = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(N_CH + 1);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_CH*DATA_W-1:0]   ch_data;
    logic                     sample_valid;
    logic                     enable;
    logic [15:0]              decim;
    logic                     frame_ack;
    logic                     frame_ready;
    logic                     rd_req;
    logic [IDX_W-1:0]         rd_idx;
    logic                     rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic [31:0]              frame_cnt;
    logic [15:0]              overrun_cnt;

    int tests = 0;
    int fails = 0;
    int caps  = 0;

    snapshot_readout_bank dut (
        .clk            (clk),
        .rst            (rst),
        .ch_data_i      (ch_data),
        .sample_valid_i (sample_valid),
        .enable_i       (enable),
        .decim_i        (decim),
        .frame_ack_i    (frame_ack),
        .frame_ready_o  (frame_ready),
        .rd_req_i       (rd_req),
        .rd_idx_i       (rd_idx),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .frame_cnt_o    (frame_cnt),
        .overrun_cnt_o  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int k = 0; k < int'(N_CH); k++) ch_data[k*DATA_W +: DATA_W] = base + 32'(k);
    endtask

    task automatic strobe(input logic ack);
        sample_valid = 1'b1;
        frame_ack    = ack;
        tick();
        sample_valid = 1'b0;
        frame_ack    = 1'b0;
    endtask

    task automatic read(input int idx, input string tag, input logic [31:0] exp);
        rd_req = 1'b1;
        rd_idx = IDX_W'(idx);
        tick();
        rd_req = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, rd_data, exp);
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; enable = 1'b1; decim = 16'd0;
        frame_ack = 1'b0; rd_req = 1'b0; rd_idx = '0; ch_data = '0;
        tick();
        rst = 1'b0;
        chk("por_ready", 32'(frame_ready), 32'd0);
        chk("por_cnt", frame_cnt, 32'd0);
        chk("por_valid", 32'(rd_valid), 32'd0);

        // Basic capture with decim=0
        set_data(32'hA000_0000);
        strobe(1'b0);
        chk("cap_ready", 32'(frame_ready), 32'd1);
        chk("cap_cnt", frame_cnt, 32'd1);
        read(3, "cap_idx3", 32'hA000_0003);
        chk("rd_idle_valid", 32'(rd_valid), 32'd1);
        tick();
        chk("rd_idle_valid0", 32'(rd_valid), 32'd0);
        chk("rd_hold_data", rd_data, 32'hA000_0003);
        read(int'(N_CH), "cap_idxcnt", 32'd1);
        read(int'(N_CH) + 1, "cap_idx_oor", 32'd0);
        read(17, "cap_idx17", 32'hA000_0011);
        ack_frame();
        chk("ack_ready", 32'(frame_ready), 32'd0);

        // Decimation by 4: captures on strobes 4, 8, 12
        decim = 16'd3;
        caps  = 0;
        for (int i = 1; i <= 12; i++) begin
            set_data(32'hB000_0000 + 32'(i) * 32'h100);
            strobe(1'b0);
            chk($sformatf("dec_ready_s%0d", i), 32'(frame_ready), 32'((i % 4) == 0));
            if (frame_ready) begin
                caps++;
                read(0, $sformatf("dec_data_s%0d", i), 32'hB000_0000 + 32'(i) * 32'h100);
                ack_frame();
            end
        end
        chk("dec_caps", 32'(caps), 32'd3);
        chk("dec_cnt", frame_cnt, 32'd4);

        // Overrun: three strobes without ack
        decim = 16'd0;
        set_data(32'hC000_0000);
        strobe(1'b0);
        set_data(32'hD000_0000);
        strobe(1'b0);
        strobe(1'b0);
        chk("ovr_cnt", 32'(overrun_cnt), 32'd2);
        chk("ovr_fcnt", frame_cnt, 32'd5);
        read(4, "ovr_keep", 32'hC000_0004);
        ack_frame();
        chk("ovr_ack_ready", 32'(frame_ready), 32'd0);

        // Capture with ack in the same cycle while holding
        set_data(32'hE000_0000);
        strobe(1'b0);
        set_data(32'hF000_0000);
        strobe(1'b1);
        chk("sim_ready", 32'(frame_ready), 32'd1);
        chk("sim_cnt", frame_cnt, 32'd7);
        chk("sim_ovr", 32'(overrun_cnt), 32'd2);
        read(5, "sim_data", 32'hF000_0005);

        // Read in the capture cycle returns the old word
        set_data(32'h9000_0000);
        rd_req = 1'b1; rd_idx = '0;
        strobe(1'b1);
        rd_req = 1'b0;
        chk("rdc_old", rd_data, 32'hF000_0000);
        chk("rdc_cnt", frame_cnt, 32'd8);
        read(0, "rdc_new", 32'h9000_0000);

        // enable=0 blocks capture
        enable = 1'b0;
        set_data(32'h1111_0000);
        strobe(1'b1);
        chk("dis_cnt", frame_cnt, 32'd8);
        chk("dis_ready", 32'(frame_ready), 32'd0);
        enable = 1'b1;

        // Reset mid-HOLD
        strobe(1'b0);
        chk("pre_rst_ready", 32'(frame_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(frame_ready), 32'd0);
        chk("rst_cnt", frame_cnt, 32'd0);
        chk("rst_ovr", 32'(overrun_cnt), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        read(0, "rst_idx0", 32'd0);

        // Runtime decrease of decim takes effect on the next strobe
        decim = 16'd5;
        strobe(1'b0);
        strobe(1'b0);
        chk("rtd_nocap", 32'(frame_ready), 32'd0);
        decim = 16'd1;
        set_data(32'h7700_0000);
        strobe(1'b0);
        chk("rtd_cap", 32'(frame_ready), 32'd1);
        read(2, "rtd_data", 32'h7700_0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
